// File: rtl/fifo_write_arbiter.sv
// Round-robin write-port arbiter for a BRAM FIFO with bounded bursts
// and occupancy-based flow control on a registered write path.
module fifo_write_arbiter #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 128,
  parameter int BURST    = 4
) (
  input  logic                        i_clock,
  input  logic                        i_reset,
  input  logic [CHANNELS-1:0]         i_request,
  input  logic [CHANNELS*WIDTH-1:0]   i_wdata,
  output logic [CHANNELS-1:0]         o_ack,
  output logic                        o_fifo_write,
  output logic [WIDTH-1:0]            o_fifo_wdata,
  input  logic [$clog2(DEPTH)-1:0]    i_fifo_queued,
  output logic [$clog2(CHANNELS)-1:0] o_owner,
  output logic                        o_busy
);

  localparam int QW = $clog2(DEPTH);
  localparam int OW = $clog2(CHANNELS);
  localparam int BW = $clog2(BURST + 1);
  localparam logic [QW:0]   LIMIT = (QW + 1)'(DEPTH - 1);
  localparam logic [BW-1:0] BMAX  = BW'(BURST);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BW-1:0]       r_burst;
  logic [BW-1:0]       w_burst_nxt;
  logic [OW-1:0]       w_owner_nxt;
  logic [OW-1:0]       w_pick;
  logic [OW-1:0]       w_sel;
  logic [OW-1:0]       w_idx;
  logic [QW:0]         w_level;
  logic [CHANNELS-1:0] w_owner_oh;
  logic                w_space;
  logic                w_any;
  logic                w_others;
  logic                w_sat;
  logic                w_hold;
  logic                w_arb;
  logic                w_xfer;

  // the pending registered write is not yet visible in the occupancy
  assign w_level    = {1'b0, i_fifo_queued} + {{QW{1'b0}}, o_fifo_write};
  assign w_space    = w_level < LIMIT;
  assign w_owner_oh = CHANNELS'(1) << o_owner;
  assign w_any      = |i_request;
  assign w_others   = |(i_request & ~w_owner_oh);
  assign w_sat      = r_burst == BMAX;
  assign w_hold     = (r_state == S_GRANT) && i_request[o_owner]
                      && !(w_sat && w_others);
  assign w_arb      = ((r_state == S_IDLE) && w_any)
                      || ((r_state == S_GRANT) && !w_hold && w_others);
  assign w_xfer     = |o_ack;
  assign o_busy     = w_any || o_fifo_write;

  // owner itself is visited last, so it wins only when alone
  always_comb begin
    w_pick = o_owner;
    w_idx  = o_owner;
    for (int k = CHANNELS; k >= 1; k--) begin
      w_idx = OW'((int'(o_owner) + k) % CHANNELS);
      if (i_request[w_idx]) w_pick = w_idx;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_burst <= '0;
      o_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_burst <= w_burst_nxt;
      o_owner <= w_owner_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = o_owner;
    w_burst_nxt = r_burst;
    if (w_arb) begin
      w_state_nxt = S_GRANT;
      w_owner_nxt = w_pick;
      w_burst_nxt = w_xfer ? BW'(1) : '0;
    end else if (w_hold) begin
      if (w_xfer && !w_sat) w_burst_nxt = r_burst + BW'(1);
    end else begin
      w_state_nxt = S_IDLE;
      w_burst_nxt = '0;
    end
  end

  always_comb begin
    w_sel = w_hold ? o_owner : w_pick;
    o_ack = '0;
    if (i_reset && w_space && (w_hold || w_arb)) o_ack[w_sel] = 1'b1;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_fifo_write <= 1'b0;
      o_fifo_wdata <= '0;
    end else begin
      o_fifo_write <= w_xfer;
      if (w_xfer) o_fifo_wdata <= i_wdata[int'(w_sel)*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized + directed bench for fifo_write_arbiter against a
// cycle-level behavioural model of the arbitration rules.
module tb_fifo_write_arbiter;

  localparam int C  = 4;
  localparam int W  = 8;
  localparam int D  = 128;
  localparam int B  = 4;
  localparam int QW = $clog2(D);
  localparam int OW = $clog2(C);

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [C-1:0]   req = '0;
  logic [C*W-1:0] wdata = '0;
  logic [C-1:0]   ack;
  logic           fw;
  logic [W-1:0]   fwd;
  logic [QW-1:0]  queued = '0;
  logic [OW-1:0]  owner;
  logic           busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .CHANNELS(C), .WIDTH(W), .DEPTH(D), .BURST(B)
  ) dut (
    .i_clock      (clk),
    .i_reset      (rst_n),
    .i_request    (req),
    .i_wdata      (wdata),
    .o_ack        (ack),
    .o_fifo_write (fw),
    .o_fifo_wdata (fwd),
    .i_fifo_queued(queued),
    .o_owner      (owner),
    .o_busy       (busy)
  );

  // model state: grant held?, owner pointer, words in current burst,
  // pending FIFO write and its data
  bit           m_g;
  int           m_own;
  int           m_burst;
  bit           m_wr;
  logic [W-1:0] m_wd;
  logic [W-1:0] d [C];
  logic [C-1:0] last_ack;
  logic         last_fw;
  logic [C-1:0] r;
  int           rr_ch;
  int           cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input int own, input logic [C-1:0] rq);
    int p;
    p = own;
    for (int k = C; k >= 1; k--) if (rq[(own + k) % C]) p = (own + k) % C;
    return p;
  endfunction

  function automatic int ch_of(input logic [C-1:0] a);
    int n;
    n = -1;
    for (int c = 0; c < C; c++) if (a[c]) n = c;
    return n;
  endfunction

  task automatic model_reset();
    m_g = 0;
    m_own = 0;
    m_burst = 0;
    m_wr = 0;
    m_wd = '0;
  endtask

  // one clock: drive, check at negedge, advance model at posedge
  task automatic step(input logic [C-1:0] rq, input int q);
    int p;
    int nown;
    int nb;
    bit ng;
    bit sp;
    bit oth;
    logic [C-1:0] ea;
    logic [C-1:0] me;
    req = rq;
    queued = QW'(q);
    for (int c = 0; c < C; c++) wdata[c*W +: W] = d[c];
    @(negedge clk);
    sp = (q + int'(m_wr)) < D - 1;
    me = C'(1) << m_own;
    oth = (rq & ~me) != 0;
    ea = '0;
    nown = m_own;
    nb = m_burst;
    ng = m_g;
    if (!m_g) begin
      if (rq != 0) begin
        p = pick(m_own, rq);
        if (sp) ea[p] = 1'b1;
        nown = p;
        ng = 1;
        nb = sp ? 1 : 0;
      end
    end else if (rq[m_own] && !(m_burst == B && oth)) begin
      if (sp) begin
        ea[m_own] = 1'b1;
        if (m_burst < B) nb = m_burst + 1;
      end
    end else if (oth) begin
      p = pick(m_own, rq);
      if (sp) ea[p] = 1'b1;
      nown = p;
      nb = sp ? 1 : 0;
    end else begin
      ng = 0;
      nb = 0;
    end
    chk("ack", 32'(ack), 32'(ea));
    chk("fifo_write", 32'(fw), 32'(m_wr));
    chk("fifo_wdata", 32'(fwd), 32'(m_wd));
    chk("owner", 32'(owner), 32'(m_own));
    chk("busy", 32'(busy), 32'((rq != 0) || m_wr));
    last_ack = ack;
    last_fw = fw;
    @(posedge clk);
    #1;
    m_wr = ea != 0;
    if (ea != 0) begin
      p = ch_of(ea);
      m_wd = d[p];
      d[p] = W'($urandom);
    end
    m_g = ng;
    m_own = nown;
    m_burst = nb;
  endtask

  // reset asserted between edges; outputs must clear with no clock
  task automatic do_reset();
    req = '1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_fw", 32'(fw), 32'h0);
    chk("rst_wdata", 32'(fwd), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    for (int c = 0; c < C; c++) d[c] = W'($urandom);
    do_reset();

    d[2] = 8'hA5;
    step(4'b0100, 0);
    chk("first_ack", 32'(last_ack), 32'h4);
    chk("first_fw", 32'(fw), 32'h1);
    chk("first_data", 32'(fwd), 32'hA5);
    step(4'b0000, 0);

    do_reset();
    for (int k = 0; k < 16; k++) begin
      step(4'b1111, 0);
      rr_ch = ((k / 4) + 1) % 4;
      chk("rr_seq", 32'(ch_of(last_ack)), 32'(rr_ch));
    end

    do_reset();
    step(4'b0001, 126);
    chk("stall_a1", 32'(last_ack), 32'h1);
    step(4'b0001, 126);
    chk("stall_hold", 32'(last_ack), 32'h0);
    chk("stall_fw", 32'(last_fw), 32'h1);
    step(4'b0001, 125);
    chk("stall_resume", 32'(last_ack), 32'h1);
    step(4'b0011, 0);
    chk("stall_b3", 32'(last_ack), 32'h1);
    step(4'b0011, 0);
    chk("stall_b4", 32'(last_ack), 32'h1);
    step(4'b0011, 0);
    chk("stall_switch", 32'(last_ack), 32'h2);

    do_reset();
    step(4'b0010, 0);
    step(4'b0010, 0);
    chk("abort_pre", 32'(last_ack), 32'h2);
    step(4'b1000, 0);
    chk("abort_switch", 32'(last_ack), 32'h8);
    step(4'b1010, 0);
    chk("abort_noack1", 32'(last_ack), 32'h8);

    do_reset();
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(4'b0001, 0);
      if (last_ack == 4'b0001) cnt++;
    end
    chk("single_20", 32'(cnt), 32'd20);

    r = '0;
    last_ack = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < C; c++) begin
        if (r[c] && !last_ack[c]) r[c] = $urandom_range(0, 31) != 0;
        else r[c] = $urandom_range(0, 2) != 0;
      end
      if ($urandom_range(0, 3) == 0) step(r, int'($urandom_range(0, 127)));
      else step(r, int'($urandom_range(122, 127)));
    end

    step(4'b1111, 0);
    step(4'b1111, 0);
    chk("pre_rst_fw", 32'(fw), 32'h1);
    do_reset();
    step(4'b1111, 0);
    chk("post_rst_ack", 32'(last_ack), 32'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
